// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and
// the helper that tells multi-cycle ops apart from single-cycle ones.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_DIVU = 4'b0100;
  localparam logic [3:0] ALU_REMU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Shared shift/add-subtract datapath: shift-add MUL and restoring
// DIVU/REMU, one bit per step; result shows the post-step value.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] result
);

  // acc: product / remainder, x: multiplicand / quotient,
  // y: multiplier / divisor
  logic [WIDTH-1:0] acc_q, x_q, y_q;
  logic [WIDTH-1:0] acc_n, x_n, y_n, pp;
  logic [WIDTH:0]   r_sh, opa, opb, sum;
  logic             div, neg;

  always_comb begin
    div  = (op == ALU_DIVU) || (op == ALU_REMU);
    pp   = y_q[0] ? x_q : '0;
    r_sh = {acc_q, x_q[WIDTH-1]};
    opa  = div ? r_sh : {1'b0, acc_q};
    opb  = div ? ~{1'b0, y_q} : {1'b0, pp};
    sum  = opa + opb + {{WIDTH{1'b0}}, div};
    // trial difference fits WIDTH+1 signed bits, so the MSB is its sign
    neg  = div & sum[WIDTH];
    if (div) begin
      acc_n = neg ? r_sh[WIDTH-1:0] : sum[WIDTH-1:0];
      x_n   = {x_q[WIDTH-2:0], ~neg};
      y_n   = y_q;
    end else begin
      acc_n = sum[WIDTH-1:0];
      x_n   = {x_q[WIDTH-2:0], 1'b0};
      y_n   = {1'b0, y_q[WIDTH-1:1]};
    end
    case (op)
      ALU_MUL, ALU_REMU: result = acc_n;
      ALU_DIVU:          result = x_n;
      default:           result = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (init) begin
      acc_q <= '0;
      x_q   <= src1;
      y_q   <= src2;
    end else if (step) begin
      acc_q <= acc_n;
      x_q   <= x_n;
      y_q   <= y_n;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU for the execute stage: start/ready/done handshake,
// single-cycle logic/arith ops plus iterative MUL/DIVU/REMU.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] res_q, fast_res, iter_res;
  logic             zero_q, accept, iter_req, last;

  assign ready_o  = (state_q != S_BUSY);
  assign done_o   = (state_q == S_DONE);
  assign accept   = start_i & ready_o;
  assign iter_req = is_iter(ctrl_i);
  assign last     = (cnt_q == CNT_W'(1));
  assign result_o = res_q;
  assign zero_o   = zero_q;

  always_comb begin
    case (ctrl_i)
      ALU_AND:  fast_res = src1_i & src2_i;
      ALU_OR:   fast_res = src1_i | src2_i;
      ALU_ADD:  fast_res = src1_i + src2_i;
      ALU_SUB:  fast_res = src1_i - src2_i;
      ALU_SLT:  fast_res = {{(WIDTH-1){1'b0}},
                            ($signed(src1_i) < $signed(src2_i))};
      ALU_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      ALU_NOR:  fast_res = ~(src1_i | src2_i);
      default:  fast_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) state_d = iter_req ? S_BUSY : S_DONE;
        else        state_d = S_IDLE;
      end
      S_BUSY: if (last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= ctrl_i;
        if (iter_req) begin
          cnt_q <= CNT_W'(WIDTH);
        end else begin
          res_q  <= fast_res;
          zero_q <= (fast_res == '0);
        end
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (last) begin
          res_q  <= iter_res;
          zero_q <= (iter_res == '0);
        end
      end
    end
  end

  alu_iter_core #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .init  (accept & iter_req),
    .step  (state_q == S_BUSY),
    .op    (op_q),
    .src1  (src1_i),
    .src2  (src2_i),
    .result(iter_res)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: scoreboard of expected results checked on done_o,
// plus inline latency/handshake checks per scenario.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] a, b;
  logic        ready, done, zero;
  logic [31:0] res;

  logic        start8;
  logic [3:0]  ctrl8;
  logic [7:0]  a8, b8;
  logic        ready8, done8, zero8;
  logic [7:0]  res8;

  typedef struct packed {
    logic [63:0] r;
    logic        z;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .ctrl_i(ctrl),
    .src1_i(a), .src2_i(b), .ready_o(ready), .done_o(done),
    .result_o(res), .zero_o(zero)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start8), .ctrl_i(ctrl8),
    .src1_i(a8), .src2_i(b8), .ready_o(ready8), .done_o(done8),
    .result_o(res8), .zero_o(zero8)
  );

  function automatic logic [63:0] model(input logic [3:0] op,
                                        input logic [63:0] x,
                                        input logic [63:0] y,
                                        input int w);
    logic [63:0] m, sb, r;
    m  = (64'd1 << w) - 64'd1;
    sb = 64'd1 << (w - 1);
    x  = x & m;
    y  = y & m;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = {63'd0, ((x ^ sb) < (y ^ sb))};
      4'b1000: r = {63'd0, (x < y)};
      4'b1100: r = ~(x | y);
      4'b0011: r = x * y;
      4'b0100: r = (y == 0) ? m : x / y;
      4'b0101: r = (y == 0) ? x : x % y;
      default: r = 64'd0;
    endcase
    return r & m;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      n_tests++;
      if (q32.size() == 0) begin
        n_fail++;
        $display("FAIL done32_unexpected result=%h", res);
      end else begin
        e = q32.pop_front();
        if ({32'd0, res} !== e.r || zero !== e.z) begin
          n_fail++;
          $display("FAIL done32 result=%h zero=%b expected %h zero=%b",
                   res, zero, e.r[31:0], e.z);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done8) begin
      n_tests++;
      if (q8.size() == 0) begin
        n_fail++;
        $display("FAIL done8_unexpected result=%h", res8);
      end else begin
        e = q8.pop_front();
        if ({56'd0, res8} !== e.r || zero8 !== e.z) begin
          n_fail++;
          $display("FAIL done8 result=%h zero=%b expected %h zero=%b",
                   res8, zero8, e.r[7:0], e.z);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] er);
    exp_t e;
    start = 1'b1;
    ctrl  = op;
    a     = x;
    b     = y;
    e.r   = er;
    e.z   = (er == 64'd0);
    q32.push_back(e);
  endtask

  // Waits from the acceptance cycle until done; cyc is the done cycle.
  task automatic wait_done(input int max, input bit hold,
                           input bit scramble, output int cyc,
                           output bit busy_ok);
    @(negedge clk);
    cyc = 1;
    busy_ok = 1'b1;
    if (!hold) start = 1'b0;
    while (done !== 1'b1 && cyc < max) begin
      if (ready !== 1'b0) busy_ok = 1'b0;
      if (scramble) begin
        a    = $urandom;
        b    = $urandom;
        ctrl = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0; ctrl = '0; a = '0; b = '0;
    start8 = 1'b0; ctrl8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0 || res !== 32'd0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset32 ready=%b done=%b result=%h zero=%b required 1 0 0 0",
               ready, done, res, zero);
    end
    n_tests++;
    if (ready8 !== 1'b1 || done8 !== 1'b0 || res8 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset8 ready=%b done=%b result=%h required 1 0 0",
               ready8, done8, res8);
    end
  endtask

  task automatic test_single;
    int cyc;
    bit ok;
    drive(4'b0010, 32'h7FFF_FFFF, 32'h1, 64'h8000_0000);
    wait_done(5, 0, 0, cyc, ok);
    n_tests++;
    if (cyc !== 1) begin
      n_fail++;
      $display("FAIL add_latency got %0d required 1", cyc);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse done=%b required 0", done);
    end
    drive(4'b0110, 32'd5, 32'd5, 64'd0);
    wait_done(5, 0, 0, cyc, ok);
    n_tests++;
    if (cyc !== 1 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_zero cyc=%0d zero=%b required 1 1", cyc, zero);
    end
    @(negedge clk);
  endtask

  task automatic test_slt;
    int cyc;
    bit ok;
    drive(4'b0111, 32'hFFFF_FFFF, 32'h1, 64'd1);
    wait_done(5, 0, 0, cyc, ok);
    n_tests++;
    if (cyc !== 1 || res !== 32'd1) begin
      n_fail++;
      $display("FAIL slt cyc=%0d result=%h required 1 1", cyc, res);
    end
    @(negedge clk);
    drive(4'b1000, 32'hFFFF_FFFF, 32'h1, 64'd0);
    wait_done(5, 0, 0, cyc, ok);
    n_tests++;
    if (cyc !== 1 || res !== 32'd0) begin
      n_fail++;
      $display("FAIL sltu cyc=%0d result=%h required 1 0", cyc, res);
    end
    @(negedge clk);
  endtask

  task automatic test_mul;
    int cyc;
    bit ok;
    drive(4'b0011, 32'h0001_0003, 32'h0001_0005, 64'h0008_000F);
    wait_done(40, 0, 0, cyc, ok);
    n_tests++;
    if (cyc !== 33 || !ok) begin
      n_fail++;
      $display("FAIL mul_timing done_cycle=%0d ready_low=%b required 33 1",
               cyc, ok);
    end
    @(negedge clk);
  endtask

  task automatic test_div;
    int cyc;
    bit ok;
    drive(4'b0100, 32'd100, 32'd7, 64'd14);
    wait_done(40, 0, 1, cyc, ok);
    n_tests++;
    if (cyc !== 33 || !ok || res !== 32'd14) begin
      n_fail++;
      $display("FAIL divu_scramble cyc=%0d result=%h required 33 e", cyc, res);
    end
    @(negedge clk);
    drive(4'b0101, 32'd100, 32'd7, 64'd2);
    wait_done(40, 0, 0, cyc, ok);
    @(negedge clk);
    drive(4'b0100, 32'd9, 32'd0, 64'hFFFF_FFFF);
    wait_done(40, 0, 0, cyc, ok);
    n_tests++;
    if (cyc !== 33) begin
      n_fail++;
      $display("FAIL divzero_latency got %0d required 33", cyc);
    end
    @(negedge clk);
    drive(4'b0101, 32'd9, 32'd0, 64'd9);
    wait_done(40, 0, 0, cyc, ok);
    @(negedge clk);
  endtask

  task automatic test_busy_start;
    int cyc;
    bit ok;
    logic [31:0] x, y;
    x = $urandom;
    y = $urandom;
    drive(4'b0011, x, y, model(4'b0011, {32'd0, x}, {32'd0, y}, 32));
    wait_done(40, 1, 0, cyc, ok);
    n_tests++;
    if (cyc !== 33 || !ok) begin
      n_fail++;
      $display("FAIL busy_start cyc=%0d ready_low=%b required 33 1", cyc, ok);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_after done=%b ready=%b required 0 1",
               done, ready);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit ok;
    logic [3:0]  ops [8];
    logic [3:0]  op;
    logic [31:0] x, y;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1000, 4'b1100, 4'b1111};
    drive(4'b0011, 32'd1234, 32'd5678, 64'd7006652);
    wait_done(40, 0, 0, cyc, ok);
    drive(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 64'h00F0_1234);
    @(negedge clk);
    n_tests++;
    if (cyc !== 33 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_and cyc=%0d done=%b required 33 1", cyc, done);
    end
    for (int i = 0; i < 8; i++) begin
      op = ops[$urandom_range(0, 7)];
      x  = $urandom;
      y  = (i == 3) ? x : $urandom;
      drive(op, x, y, model(op, {32'd0, x}, {32'd0, y}, 32));
      @(negedge clk);
      n_tests++;
      if (done !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_stream i=%0d done=%b required 1", i, done);
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end done=%b required 0", done);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit ok;
    bit quiet;
    drive(4'b0010, 32'd1, 32'd1, 64'd2);
    wait_done(5, 0, 0, cyc, ok);
    @(negedge clk);
    drive(4'b0100, 32'd1000, 32'd3, 64'd333);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0 || res !== 32'd0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid ready=%b done=%b result=%h zero=%b required 1 0 0 0",
               ready, done, res, zero);
    end
    q32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL reset_mid_done done seen after abort, required none");
    end
  endtask

  task automatic test_width8;
    int   cyc;
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; ctrl8 = 4'b0011; a8 = 8'h0F; b8 = 8'h11;
    e.r = 64'hFF; e.z = 1'b0;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc !== 9 || res8 !== 8'hFF) begin
      n_fail++;
      $display("FAIL mul8 cyc=%0d result=%h required 9 ff", cyc, res8);
    end
    start8 = 1'b1; ctrl8 = 4'b1111; a8 = 8'h5A; b8 = 8'hA5;
    e.r = 64'd0; e.z = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    n_tests++;
    if (done8 !== 1'b1 || res8 !== 8'h00 || zero8 !== 1'b1) begin
      n_fail++;
      $display("FAIL undef8 done=%b result=%h zero=%b required 1 00 1",
               done8, res8, zero8);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_slt;
    test_mul;
    test_div;
    test_busy_start;
    test_back_to_back;
    test_reset_mid;
    test_width8;
    repeat (2) @(negedge clk);
    n_tests++;
    if (q32.size() != 0 || q8.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending32=%0d pending8=%0d required 0 0",
               q32.size(), q8.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the team's 32-bit combinational ALU. It keeps the existing 4-bit operation codes, adds signed/unsigned compare, NOR, iterative multiply and unsigned divide/remainder, and uses a start/ready/done handshake. It sits in the execute stage of the multi-cycle CPU, and the control unit stalls on `ready_o`. `zero_o` is valid for every operation, not only SUB.

## Interface
- `WIDTH`, default 32: operand/result width; legal range 4..64.
- `CNT_W`, default `$clog2(WIDTH+1)`: iteration counter width; derived, not overridden.

- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  request; accepted on a rising edge where `start_i & ready_o`.
- `ctrl_i`  in  4  operation code, sampled at acceptance.
- `src1_i`  in  WIDTH  operand A, sampled at acceptance.
- `src2_i`  in  WIDTH  operand B, sampled at acceptance.
- `ready_o`  out  1  can accept a request; reset value 1.
- `done_o`  out  1  one-cycle pulse: `result_o`/`zero_o` are new this cycle; reset value 0.
- `result_o`  out  WIDTH  registered result, held until the next `done_o`; reset value 0.
- `zero_o`  out  1  `result_o == 0`, registered alongside it; reset value 0.

## Operation
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT, signed
  - 1000 SLTU, unsigned
  - 1100 NOR
  - 0011 MUL, low WIDTH bits of the product
  - 0100 DIVU
  - 0101 REMU
- Any other code: result 0, `zero_o` = 1, single-cycle timing.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- SLT/SLTU produce 1 or 0, zero-extended to WIDTH.
- MUL: shift-add, one partial product per cycle, WIDTH iterations; the signed and unsigned low halves are identical.
- DIVU/REMU: restoring division, one quotient bit per cycle, WIDTH iterations.
- Divide by zero: DIVU gives all ones, REMU gives the dividend. It still takes the full WIDTH iterations.
- Operands are captured in internal registers at acceptance; later changes on `src*_i` and `ctrl_i` have no effect.
- FSM states:
  - IDLE: `ready_o` = 1. On acceptance, a single-cycle op goes to DONE and an iterative op goes to BUSY with counter = WIDTH.
  - BUSY: `ready_o` = 0. Counter decrements each cycle. When the counter reaches 1, go to DONE.
  - DONE: `done_o` = 1, `ready_o` = 1. A new acceptance in this cycle goes to DONE or BUSY as in IDLE; otherwise go to IDLE.
- `start_i` while BUSY is ignored, not queued.
- Reset asserted at any time, including mid-BUSY: the operation is aborted, FSM goes to IDLE, and all outputs return to their reset values immediately.

## Timing
- Cycle 0 is the cycle in which `start_i & ready_o` is high; acceptance occurs at its closing edge.
- Single-cycle ops: `done_o` is high in cycle 1 (latency 1).
- MUL/DIVU/REMU: `done_o` is high in cycle WIDTH+1 (latency 33 at default); `ready_o` is low in cycles 1..WIDTH.
- Back-to-back: a request accepted in a DONE cycle produces its `done_o` exactly one latency later. Single-cycle ops can therefore sustain one result per cycle, with `done_o` held high.
- `result_o` and `zero_o` change only on a `done_o` cycle or on reset.

## Structure
- Shared package `alu_pkg`:
  - op-code localparams (`ALU_AND` … `ALU_REMU`);
  - FSM state enum (`S_IDLE`, `S_BUSY`, `S_DONE`);
  - function `is_iter(op)`.
- Sub-module `alu_iter_core`:
  - shared shift/add-subtract datapath for MUL and restoring DIVU/REMU;
  - ports: `init`, `step`, `op`, operands, `result`.
- The top level owns the FSM, the counter, the single-cycle datapath and the output registers.

## Test plan
- Reset-release values, then a single-cycle op:
  - After reset release: `ready_o` = 1, `done_o` = 0, `result_o` = 0.
  - ADD 0x7FFFFFFF + 1 → `done_o` in cycle 1, `result_o` = 0x80000000, `zero_o` = 0.
  - SUB 5−5 → `result_o` = 0, `zero_o` = 1.
- SLT vs SLTU: `src1_i` = 0xFFFFFFFF, `src2_i` = 1 → SLT = 1, SLTU = 0.
- MUL 0x0001_0003 × 0x0001_0005 → `ready_o` low cycles 1..32, `done_o` in cycle 33, `result_o` = 0x0008_000F.
- DIVU/REMU:
  - 100 / 7 → quotient 14; REMU gives 2.
  - DIVU 9 / 0 → 0xFFFFFFFF; REMU 9 / 0 → 9.
  - Operands change mid-BUSY → result unchanged.
- Handshake edge cases:
  - `start_i` held high while BUSY → ignored.
  - New AND accepted in the DONE cycle of a MUL → `done_o` again one cycle later.
  - Reset pulsed in cycle 10 of a DIVU → all outputs reset at once, no `done_o`.
- Parametric: `WIDTH` = 8 → MUL 0x0F × 0x11 = 0xFF in 9 cycles; undefined op 1111 → 0, `zero_o` = 1.
